// File: rtl/round_cipher_core.sv
// Iterative rotate/XOR block cipher core, one round per clock.
// Encrypt and decrypt share one datapath; the round key is rotated each
// round, so no key schedule is stored.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    input handshake (block accepted on both high)
//   mode                  0 = encrypt, 1 = decrypt (sampled on accept)
//   data_in, key_in       block and master key (sampled on accept)
//   out_valid, out_ready  output handshake (result held until taken)
//   data_out              result block
//   busy                  core is in ROUND or DONE
module round_cipher_core #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned KEY_SHIFT = 3,
  parameter int unsigned DATA_ROT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int unsigned CNT_W       = $clog2(ROUNDS + 1);
  localparam int unsigned KS          = KEY_SHIFT % DATA_W;
  localparam int unsigned DR          = DATA_ROT % DATA_W;
  // Decrypt starts from the last encrypt round key and walks backwards.
  localparam int unsigned DEC_KEY_ROT = (KEY_SHIFT * ROUNDS) % DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   s_reg;
  logic [DATA_W-1:0]   k_reg;
  logic                mode_reg;
  logic [CNT_W-1:0]    rnd_cnt;
  logic [DATA_W-1:0]   s_next;
  logic [DATA_W-1:0]   k_next;

  // Circular left rotate; amount reduced modulo DATA_W.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                             input int unsigned n);
    int unsigned a;
    a = n % DATA_W;
    if (a == 0) return x;
    return (x << a) | (x >> (DATA_W - a));
  endfunction

  // Circular right rotate expressed as the complementary left rotate.
  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input int unsigned n);
    return rotl(x, (DATA_W - (n % DATA_W)) % DATA_W);
  endfunction

  // One round of state and key update for the current direction.
  always_comb begin
    s_next = s_reg;
    k_next = k_reg;
    if (mode_reg) begin
      s_next = rotr(s_reg ^ k_reg, DR);
      k_next = rotr(k_reg, KS);
    end else begin
      s_next = rotl(s_reg, DR) ^ k_reg;
      k_next = rotl(k_reg, KS);
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      s_reg     <= '0;
      k_reg     <= '0;
      mode_reg  <= 1'b0;
      rnd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            s_reg    <= data_in;
            mode_reg <= mode;
            rnd_cnt  <= '0;
            k_reg    <= mode ? rotl(key_in, DEC_KEY_ROT) : rotl(key_in, KS);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          s_reg   <= s_next;
          k_reg   <= k_next;
          rnd_cnt <= rnd_cnt + CNT_W'(1);
          if (rnd_cnt == CNT_W'(ROUNDS - 1)) begin
            data_out  <= s_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result stays put until downstream takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_cipher_core.sv
// Self-checking bench for round_cipher_core: a ROUNDS=4 instance for the
// main vectors and a ROUNDS=1 instance for the single-round corner case.
// Both share stimulus; sel picks which instance's outputs are observed.
module tb_round_cipher_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        mode;
  logic [63:0] data_in;
  logic [63:0] key_in;
  logic        out_ready;
  logic        sel;

  logic        ir4, ov4, bz4;
  logic [63:0] do4;
  logic        ir1, ov1, bz1;
  logic [63:0] do1;

  logic        in_ready_s, out_valid_s, busy_s;
  logic [63:0] data_out_s;

  int n_pass;
  int n_total;

  assign in_ready_s  = sel ? ir1 : ir4;
  assign out_valid_s = sel ? ov1 : ov4;
  assign busy_s      = sel ? bz1 : bz4;
  assign data_out_s  = sel ? do1 : do4;

  round_cipher_core #(.DATA_W(64), .ROUNDS(4), .KEY_SHIFT(3), .DATA_ROT(5)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .mode(mode),
    .data_in(data_in), .key_in(key_in), .out_valid(ov4), .out_ready(out_ready),
    .data_out(do4), .busy(bz4)
  );

  round_cipher_core #(.DATA_W(64), .ROUNDS(1), .KEY_SHIFT(3), .DATA_ROT(5)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .mode(mode),
    .data_in(data_in), .key_in(key_in), .out_valid(ov1), .out_ready(out_ready),
    .data_out(do1), .busy(bz1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rl(input logic [63:0] x, input int n);
    int a;
    a = n % 64;
    if (a == 0) return x;
    return (x << a) | (x >> (64 - a));
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return rl(x, (64 - (n % 64)) % 64);
  endfunction

  // Reference: explicit per-round key k_i = rotl(key, 3*(i+1)).
  function automatic logic [63:0] model(input logic m, input logic [63:0] key,
                                        input logic [63:0] d, input int rounds);
    logic [63:0] s;
    s = d;
    if (!m) begin
      for (int i = 0; i < rounds; i++) s = rl(s, 5) ^ rl(key, 3 * (i + 1));
    end else begin
      for (int i = rounds - 1; i >= 0; i--) s = rr(s ^ rl(key, 3 * (i + 1)), 5);
    end
    return s;
  endfunction

  // Offer one block, wait for the result, hold it under backpressure, then take it.
  task automatic do_block(input logic m, input logic [63:0] k, input logic [63:0] d,
                          input int hold, output logic [63:0] res);
    int n;
    int lat;
    int exp_lat;
    logic stable;
    exp_lat = sel ? 2 : 5;
    res = '0;
    @(negedge clk);
    in_valid = 1'b1; mode = m; key_in = k; data_in = d; out_ready = 1'b0;
    n = 0;
    while (!in_ready_s && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 64'(n < 50), 64'd1);
    if (n >= 50) begin in_valid = 1'b0; return; end
    @(negedge clk);
    // Scramble inputs that the block in flight must ignore.
    in_valid = 1'b0; mode = ~m; key_in = {$urandom, $urandom}; data_in = {$urandom, $urandom};
    chk("busy_after_accept", {62'd0, busy_s, in_ready_s}, 64'd2);
    lat = 1;
    while (!out_valid_s && lat < 50) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    res = data_out_s;
    stable = in_ready_s ? 1'b0 : 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_valid_s || data_out_s !== res || in_ready_s) stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_take_out_valid", 64'(out_valid_s), 64'd0);
  endtask

  typedef struct {
    logic        m;
    logic [63:0] key;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl[8];
  logic [63:0] r;
  logic [63:0] c;
  logic [63:0] q[$];
  int          last_acc;

  initial begin
    n_pass = 0; n_total = 0; sel = 1'b0;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; data_in = '0; key_in = '0; out_ready = 1'b0;

    tbl[0] = '{1'b0, 64'h0, 64'h1, 64'h0000_0000_0010_0000};
    tbl[1] = '{1'b1, 64'h0, 64'h0000_0000_0010_0000, 64'h1};
    tbl[2] = '{1'b0, 64'h0, 64'h8000_0000_0000_0000, 64'h0000_0000_0008_0000};
    tbl[3] = '{1'b1, 64'h0, 64'h0000_0000_0008_0000, 64'h8000_0000_0000_0000};
    tbl[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    tbl[5] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
    tbl[6] = '{1'b0, 64'h1, 64'h0, 64'h0000_0000_0005_5000};
    tbl[7] = '{1'b1, 64'h1, 64'h0000_0000_0005_5000, 64'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_s), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_data_out", data_out_s, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_s), 64'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      do_block(tbl[i].m, tbl[i].key, tbl[i].data, i % 4, r);
      chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    // Random round trips with random backpressure.
    for (int i = 0; i < 500; i++) begin
      logic [63:0] k;
      logic [63:0] d;
      k = {$urandom, $urandom};
      d = {$urandom, $urandom};
      do_block(1'b0, k, d, $urandom_range(0, 10), c);
      chk("rt_enc", c, model(1'b0, k, d, 4));
      do_block(1'b1, k, c, $urandom_range(0, 10), r);
      chk("rt_dec", r, d);
    end

    // Reset in the second ROUND cycle discards the block.
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b0; key_in = 64'h1234; data_in = 64'h5678;
    begin
      int n;
      n = 0;
      while (!in_ready_s && n < 50) begin @(negedge clk); n++; end
      chk("rst_test_accept", 64'(n < 50), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid_s), 64'd0);
    chk("midrst_busy", 64'(busy_s), 64'd0);
    @(negedge clk);
    chk("midrst_next", {61'd0, in_ready_s, out_valid_s, busy_s}, 64'd4);
    do_block(1'b0, 64'h1, 64'h0, 2, r);
    chk("after_rst_block", r, 64'h0000_0000_0005_5000);

    // Continuous in_valid with fresh data every cycle.
    last_acc = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cy = 0; cy < 40; cy++) begin
      if (out_valid_s) begin
        if (q.size() == 0) chk("stream_unexpected_out", 64'd1, 64'd0);
        else chk("stream_data", data_out_s, q.pop_front());
      end
      data_in = {$urandom, $urandom};
      key_in = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      if (in_ready_s) begin
        q.push_back(model(mode, key_in, data_in, 4));
        if (last_acc >= 0) chk("stream_spacing", 64'(cy - last_acc), 64'd6);
        last_acc = cy;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int cy = 0; cy < 10 && q.size() != 0; cy++) begin
      if (out_valid_s) chk("stream_drain", data_out_s, q.pop_front());
      @(negedge clk);
    end
    chk("stream_all_out", 64'(q.size()), 64'd0);
    out_ready = 1'b0;

    // Single-round instance.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    do_block(1'b0, 64'h1, 64'h0, 3, r);
    chk("r1_enc", r, 64'h8);
    do_block(1'b1, 64'h1, 64'h8, 0, r);
    chk("r1_dec", r, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
